mac_stop_seq: RTL
=================

Name: mac_stop_seq

Overview:
Matrix-multiply sequencer that initiates accesses on the matrix memory port set and computes C = A x B.
- Reads A[i][k] and B[k][j] through the memory's combinational read ports and accumulates K products per output element.
- Writes each finished element into C through the memory's write port.
- Host handshake: start/done, plus a stop input that aborts cleanly with no partial write.
- Sits between the host loader (fills A/B, reads back C) and the matrix memory, and owns the memory address buses while busy.

Parameters:
M, 4, rows of A and C
K, 4, columns of A / rows of B (MAC length)
N, 4, columns of B and C
DW, 32, operand width of A/B elements
RW, 2*DW+$clog2(K), C element / accumulator width
AW_A, $clog2(M), row index width of A and C
AW_B, $clog2(K), k index width
AW_C, $clog2(N), column index width of B and C

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
start  in  1  begin a multiply; sampled only in IDLE
stop  in  1  abort the current multiply
busy  out  1  high in MAC and WRITE states
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse after a stop
row_addr_a  out  AW_A  A row index i
col_addr_a  out  AW_B  A column index k
row_addr_b  out  AW_B  B row index k
col_addr_b  out  AW_C  B column index j
row_addr_c  out  AW_A  C row index i
col_addr_c  out  AW_C  C column index j
matrix_a_re  out  1  A read enable, high in MAC
matrix_b_re  out  1  B read enable, high in MAC
matrix_c_we  out  1  C write strobe, high in WRITE
data_in_c  out  RW  accumulator value written to C
data_out_a  in  DW  A element at the current address, same cycle
data_out_b  in  DW  B element at the current address, same cycle

Behaviour:
- Reset (async, resetn low):
  - State IDLE; i=j=k=0; acc=0.
  - All outputs 0: busy, done, aborted, all addresses, re/we strobes, data_in_c.
  - Reset mid-operation abandons the run. No done and no aborted pulse are generated.
- FSM states: IDLE, MAC, WRITE, DONE. Registered outputs.
- IDLE:
  - Addresses and strobes are 0.
  - start=1 and stop=0: clear i,j,k,acc, go to MAC.
  - stop in IDLE is ignored. start and stop together in IDLE: stay in IDLE, no pulse.
- MAC:
  - Drive addr A=(i,k), addr B=(k,j); matrix_a_re=matrix_b_re=1.
  - acc <= acc + data_out_a*data_out_b, with the product zero-extended to RW.
  - k increments. When k==K-1, k wraps to 0 and the state goes to WRITE.
- WRITE:
  - row_addr_c=i, col_addr_c=j, data_in_c=acc, matrix_c_we=1 for exactly one cycle.
  - acc <= 0.
  - Advance j. On j wrap (N-1 -> 0), advance i.
  - If i==M-1 and j==N-1, go to DONE; otherwise go to MAC.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Timing:
  - Each element takes K+1 cycles.
  - With start accepted in cycle 0, the first C write occurs in cycle K+1.
  - done is high in cycle M*N*(K+1)+1 (81 at defaults).
- Overflow: RW is sized so that K maximal products never overflow. No saturation logic.
- start while busy is ignored.
- stop in MAC or WRITE:
  - stop has priority. matrix_c_we is forced low that cycle, so no partial element is written.
  - Next cycle: state IDLE, aborted=1 for one cycle, done stays 0, acc cleared.
  - C elements written before the stop remain valid.
- stop in DONE: ignored; done still pulses.
- Wrap-around: the i, j, k counters are bounded by M-1, N-1, K-1 even when a dimension is not a power of two.

Optional Feature:
MAC_SIGNED_EN
- Defined: data_out_a and data_out_b are two's-complement. The product is a signed 2*DW value, sign-extended to RW before accumulation. data_in_c is a signed RW value.
- Undefined: unsigned operands, zero extension. This is the default.

Test Plan:
- Normal multiply: A=identity, B[r][c]=4r+c+1, pulse start -> C[r][c]=4r+c+1 for all 16 elements; exactly 16 matrix_c_we pulses; done high only in cycle 81 after start; busy low after done.
- Maximum operands: all A=B=0xFFFFFFFF (unsigned) -> every C element = 4*(2^32-1)^2 = 0x3_FFFF_FFF8_0000_0004 with no truncation.
- Stop mid-run: start in cycle 0, stop high in cycle 12 -> only C[0][0] and C[0][1] written (cycles 5 and 10); no write in cycle 12; aborted=1 in cycle 13; done never asserted; a new start then completes normally.
- Stop during a WRITE cycle: stop high in cycle 5 -> matrix_c_we=0 in cycle 5, C[0][0] unchanged, aborted in cycle 6.
- Handshake corners:
  - start pulsed again in cycle 20 -> ignored; done still in cycle 81.
  - start and stop together in IDLE -> stays IDLE, no pulses.
  - resetn low in cycle 30 -> all outputs 0 immediately, no done or aborted pulse.
- MAC_SIGNED_EN: A row 0 = {-1,2,-3,4}, B column 0 = {5,-6,7,8} -> C[0][0] = -5-12-21+32 = -6, i.e. all-ones except LSB pattern 0x...FFFA in RW bits.

Source files
------------

// File: rtl/mac_stop_seq.sv
// Matrix-multiply sequencer: C = A x B over a combinational-read matrix memory,
// with start/done handshake and clean stop. Define MAC_SIGNED_EN for signed operands.
module mac_stop_seq #(
  parameter int M    = 4,
  parameter int K    = 4,
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int RW   = 2*DW + $clog2(K),
  parameter int AW_A = $clog2(M),
  parameter int AW_B = $clog2(K),
  parameter int AW_C = $clog2(N)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            stop,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [AW_A-1:0] row_addr_a,
  output logic [AW_B-1:0] col_addr_a,
  output logic [AW_B-1:0] row_addr_b,
  output logic [AW_C-1:0] col_addr_b,
  output logic [AW_A-1:0] row_addr_c,
  output logic [AW_C-1:0] col_addr_c,
  output logic            matrix_a_re,
  output logic            matrix_b_re,
  output logic            matrix_c_we,
  output logic [RW-1:0]   data_in_c,
  input  logic [DW-1:0]   data_out_a,
  input  logic [DW-1:0]   data_out_b
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  localparam logic [AW_A-1:0] I_MAX = AW_A'(M-1);
  localparam logic [AW_B-1:0] K_MAX = AW_B'(K-1);
  localparam logic [AW_C-1:0] J_MAX = AW_C'(N-1);

  state_t          state;
  logic [AW_A-1:0] i;
  logic [AW_B-1:0] k;
  logic [AW_C-1:0] j;
  logic [RW-1:0]   acc;
  logic            c_we_q;

  logic [2*DW-1:0] prod;
  logic [RW-1:0]   prod_ext;
  logic [RW-1:0]   acc_sum;
  logic            k_last;
  logic            j_last;
  logic            i_last;
  logic [AW_A-1:0] i_next;
  logic [AW_C-1:0] j_next;

  always_comb begin
`ifdef MAC_SIGNED_EN
    prod     = $signed({{DW{data_out_a[DW-1]}}, data_out_a}) *
               $signed({{DW{data_out_b[DW-1]}}, data_out_b});
    prod_ext = {{(RW-2*DW){prod[2*DW-1]}}, prod};
`else
    prod     = {{DW{1'b0}}, data_out_a} * {{DW{1'b0}}, data_out_b};
    prod_ext = {{(RW-2*DW){1'b0}}, prod};
`endif
    acc_sum  = acc + prod_ext;
    k_last   = (k == K_MAX);
    j_last   = (j == J_MAX);
    i_last   = (i == I_MAX);
    j_next   = j_last ? '0 : j + AW_C'(1);
    i_next   = j_last ? (i_last ? '0 : i + AW_A'(1)) : i;
  end

  // The write strobe is registered but masked by stop in the same cycle, so an
  // aborted WRITE never reaches memory.
  assign matrix_c_we = c_we_q & ~stop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      row_addr_a  <= '0;
      col_addr_a  <= '0;
      row_addr_b  <= '0;
      col_addr_b  <= '0;
      row_addr_c  <= '0;
      col_addr_c  <= '0;
      matrix_a_re <= 1'b0;
      matrix_b_re <= 1'b0;
      c_we_q      <= 1'b0;
      data_in_c   <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (stop && (state == S_MAC || state == S_WRITE)) begin
        state       <= S_IDLE;
        aborted     <= 1'b1;
        busy        <= 1'b0;
        i           <= '0;
        j           <= '0;
        k           <= '0;
        acc         <= '0;
        row_addr_a  <= '0;
        col_addr_a  <= '0;
        row_addr_b  <= '0;
        col_addr_b  <= '0;
        row_addr_c  <= '0;
        col_addr_c  <= '0;
        matrix_a_re <= 1'b0;
        matrix_b_re <= 1'b0;
        c_we_q      <= 1'b0;
        data_in_c   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              state       <= S_MAC;
              i           <= '0;
              j           <= '0;
              k           <= '0;
              acc         <= '0;
              busy        <= 1'b1;
              matrix_a_re <= 1'b1;
              matrix_b_re <= 1'b1;
              row_addr_a  <= '0;
              col_addr_a  <= '0;
              row_addr_b  <= '0;
              col_addr_b  <= '0;
            end
          end
          S_MAC: begin
            acc <= acc_sum;
            if (k_last) begin
              state       <= S_WRITE;
              k           <= '0;
              matrix_a_re <= 1'b0;
              matrix_b_re <= 1'b0;
              row_addr_a  <= '0;
              col_addr_a  <= '0;
              row_addr_b  <= '0;
              col_addr_b  <= '0;
              c_we_q      <= 1'b1;
              row_addr_c  <= i;
              col_addr_c  <= j;
              data_in_c   <= acc_sum;
            end else begin
              k          <= k + AW_B'(1);
              col_addr_a <= k + AW_B'(1);
              row_addr_b <= k + AW_B'(1);
            end
          end
          S_WRITE: begin
            acc        <= '0;
            c_we_q     <= 1'b0;
            row_addr_c <= '0;
            col_addr_c <= '0;
            data_in_c  <= '0;
            i          <= i_next;
            j          <= j_next;
            if (i_last && j_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state       <= S_MAC;
              matrix_a_re <= 1'b1;
              matrix_b_re <= 1'b1;
              row_addr_a  <= i_next;
              col_addr_a  <= '0;
              row_addr_b  <= '0;
              col_addr_b  <= j_next;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
